// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, ExcCodes, STATUS bit positions and sequencer states.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;
    localparam logic [4:0] EXC_TRAP    = 5'd13;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;

    // Bit positions inside exc_flags = {eret, ov, trap, ri, syscall}
    localparam int FLAG_SYSCALL = 0;
    localparam int FLAG_RI      = 1;
    localparam int FLAG_TRAP    = 2;
    localparam int FLAG_OV      = 3;
    localparam int FLAG_ERET    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_EPC,
        S_W_STATUS,
        S_W_CAUSE,
        S_REDIR
    } seq_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder for MEM-stage events: INT > RI > OV > TRAP > SYSCALL > ERET.
module exc_prio_enc
    import cp0_pkg::*;
(
    input  logic       int_pend,
    input  logic [4:0] exc_flags,
    output logic       hit,
    output logic [4:0] code,
    output logic       is_eret
);

    // NOTE: every output gets a default before the if-chain so no path leaves one unassigned (no latch).
    always_comb begin
        hit     = 1'b1;
        code    = EXC_INT;
        is_eret = 1'b0;
        if (int_pend) begin
            code = EXC_INT;
        end else if (exc_flags[FLAG_RI]) begin
            code = EXC_RI;
        end else if (exc_flags[FLAG_OV]) begin
            code = EXC_OV;
        end else if (exc_flags[FLAG_TRAP]) begin
            code = EXC_TRAP;
        end else if (exc_flags[FLAG_SYSCALL]) begin
            code = EXC_SYSCALL;
        end else if (exc_flags[FLAG_ERET]) begin
            is_eret = 1'b1;  // ERET reports code 0
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_exc_seq.sv
// Exception entry / ERET sequencer owning the CP0 write port; serializes EPC/STATUS/CAUSE then redirects.
// Optional EXC_CNT_EN adds a saturating exception counter output exc_cnt_o.
module cp0_exc_seq
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [4:0]  exc_flags_i,
    input  logic [31:0] pc_i,
    input  logic        in_dslot_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        mtc0_we_i,
    input  logic [4:0]  mtc0_waddr_i,
    input  logic [31:0] mtc0_data_i,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_data_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [4:0]  exc_code_o
`ifdef EXC_CNT_EN
    ,
    output logic [15:0] exc_cnt_o
`endif
);

    seq_state_e  state, state_nxt;
    logic        int_pend, hit, is_eret, trigger;
    logic [4:0]  code;

    logic [31:0] pc_snap, status_snap, cause_snap, epc_snap;
    logic        dslot_snap, exl_snap, eret_snap;
    logic        unused_cause;

    assign int_pend = (|(cause_i[STATUS_IM_HI:STATUS_IM_LO] & status_i[STATUS_IM_HI:STATUS_IM_LO]))
                    & status_i[STATUS_IE] & ~status_i[STATUS_EXL];

    exc_prio_enc u_prio (
        .int_pend  (int_pend),
        .exc_flags (exc_flags_i),
        .hit       (hit),
        .code      (code),
        .is_eret   (is_eret)
    );

    assign trigger = (state == S_IDLE) & inst_valid_i & hit;

    // The ExcCode field of CAUSE is rebuilt from the event code, not the snapshot.
    assign unused_cause = ^cause_snap[6:2];

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_snap     <= '0;
            status_snap <= '0;
            cause_snap  <= '0;
            epc_snap    <= '0;
            dslot_snap  <= 1'b0;
            exl_snap    <= 1'b0;
            eret_snap   <= 1'b0;
            exc_code_o  <= '0;
        end else if (trigger) begin
            pc_snap     <= pc_i;
            status_snap <= status_i;
            cause_snap  <= cause_i;
            epc_snap    <= epc_i;
            dslot_snap  <= in_dslot_i;
            exl_snap    <= status_i[STATUS_EXL];
            eret_snap   <= is_eret;
            exc_code_o  <= code;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    // ERET and nested exceptions (EXL already set) leave EPC untouched
                    state_nxt = (is_eret || status_i[STATUS_EXL]) ? S_W_STATUS : S_W_EPC;
                end
            end
            S_W_EPC:    state_nxt = S_W_STATUS;
            S_W_STATUS: state_nxt = eret_snap ? S_REDIR : S_W_CAUSE;
            S_W_CAUSE:  state_nxt = S_REDIR;
            S_REDIR:    state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while rst is high so an aborted sequence issues no write.
    always_comb begin
        cp0_we_o    = 1'b0;
        cp0_waddr_o = '0;
        cp0_data_o  = '0;
        stall_o     = 1'b0;
        flush_o     = 1'b0;
        new_pc_o    = '0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    cp0_we_o    = mtc0_we_i;
                    cp0_waddr_o = mtc0_waddr_i;
                    cp0_data_o  = mtc0_data_i;
                end
                S_W_EPC: begin
                    cp0_we_o    = 1'b1;
                    cp0_waddr_o = CP0_EPC;
                    cp0_data_o  = dslot_snap ? (pc_snap - 32'd4) : pc_snap;
                    stall_o     = 1'b1;
                end
                S_W_STATUS: begin
                    cp0_we_o    = 1'b1;
                    cp0_waddr_o = CP0_STATUS;
                    cp0_data_o  = eret_snap ? (status_snap & ~32'h2) : (status_snap | 32'h2);
                    stall_o     = 1'b1;
                end
                S_W_CAUSE: begin
                    cp0_we_o    = 1'b1;
                    cp0_waddr_o = CP0_CAUSE;
                    cp0_data_o  = {exl_snap ? cause_snap[31] : dslot_snap,
                                   cause_snap[30:7], exc_code_o, cause_snap[1:0]};
                    stall_o     = 1'b1;
                end
                S_REDIR: begin
                    flush_o  = 1'b1;
                    new_pc_o = eret_snap ? epc_snap : EXC_VECTOR;
                end
                default: ;
            endcase
        end
    end

`ifdef EXC_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_cnt_o <= '0;
        end else if (state == S_REDIR && !eret_snap && exc_cnt_o != 16'hFFFF) begin
            exc_cnt_o <= exc_cnt_o + 16'd1;
        end
    end
`endif

endmodule
